uart_tx_arbiter: RTL and testbench

// - Shares one UART TX FIFO write port among NumReq byte-stream requesters.
// - Grants at packet granularity. Arbitration is round-robin. A packet is capped at MaxPktLen bytes.
// - Sits between firmware/DMA byte sources and the UART TX FIFO write interface.
// - Guarantees bytes of different requesters never interleave inside a packet.

---
 rtl/uart_tx_arbiter.sv | 116 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin arbiter that lets NumReq byte
// sources share a single UART TX FIFO write port.
`timescale 1ns/1ps
module uart_tx_arbiter #(
  parameter int unsigned NumReq    = 4,
  parameter int unsigned MaxPktLen = 16,
  localparam int unsigned IdW      = $clog2(NumReq),
  localparam int unsigned CntW     = $clog2(MaxPktLen + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                enable_i,
  input  logic [NumReq-1:0]   req_valid_i,
  input  logic [NumReq*8-1:0] req_data_i,
  input  logic [NumReq-1:0]   req_last_i,
  output logic [NumReq-1:0]   req_ready_o,
  output logic                fifo_wvalid_o,
  output logic [7:0]          fifo_wdata_o,
  input  logic                fifo_wready_i,
  output logic                busy_o,
  output logic [IdW-1:0]      gnt_id_o,
  output logic                pkt_done_o,
  output logic                trunc_o
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t          state;
  logic [IdW-1:0]  rr_ptr;
  logic [CntW-1:0] cnt;

  logic [IdW-1:0]  cand;
  logic [IdW-1:0]  pick;
  logic            pick_vld;
  logic            gnt_last;
  logic            hs;
  logic            eop;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    cand     = '0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = 1; k <= int'(NumReq); k++) begin
      cand = IdW'((32'(rr_ptr) + 32'(k)) % NumReq);
      if (!pick_vld && req_valid_i[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  // Pass the granted requester straight through to the FIFO while in XFER.
  always_comb begin
    fifo_wvalid_o = 1'b0;
    fifo_wdata_o  = '0;
    req_ready_o   = '0;
    gnt_last      = 1'b0;
    if (state == XFER) begin
      fifo_wvalid_o = req_valid_i[gnt_id_o];
      gnt_last      = req_last_i[gnt_id_o];
      req_ready_o[gnt_id_o] = fifo_wready_i;
      if (req_valid_i[gnt_id_o]) begin
        for (int i = 0; i < int'(NumReq); i++) begin
          if (gnt_id_o == IdW'(i)) fifo_wdata_o = req_data_i[8*i +: 8];
        end
      end
    end
  end

  assign hs  = fifo_wvalid_o && fifo_wready_i;
  assign eop = hs && (gnt_last || (cnt == CntW'(MaxPktLen - 1)));

  // Grant / release FSM with registered status outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      rr_ptr     <= IdW'(NumReq - 1);
      cnt        <= '0;
      gnt_id_o   <= '0;
      busy_o     <= 1'b0;
      pkt_done_o <= 1'b0;
      trunc_o    <= 1'b0;
    end else begin
      pkt_done_o <= 1'b0;
      trunc_o    <= 1'b0;
      case (state)
        IDLE: begin
          if (enable_i && pick_vld) begin
            state    <= XFER;
            busy_o   <= 1'b1;
            gnt_id_o <= pick;
            rr_ptr   <= pick;
            cnt      <= '0;
          end
        end
        XFER: begin
          if (hs) begin
            cnt <= cnt + CntW'(1);
            if (eop) begin
              state      <= IDLE;
              busy_o     <= 1'b0;
              pkt_done_o <= 1'b1;
              trunc_o    <= !gnt_last;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NumReq=4, MaxPktLen=16).
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int unsigned NumReq    = 4;
  localparam int unsigned MaxPktLen = 16;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              enable_i;
  logic [NumReq-1:0] req_valid_i;
  logic [NumReq*8-1:0] req_data_i;
  logic [NumReq-1:0] req_last_i;
  logic [NumReq-1:0] req_ready_o;
  logic              fifo_wvalid_o;
  logic [7:0]        fifo_wdata_o;
  logic              fifo_wready_i;
  logic              busy_o;
  logic [1:0]        gnt_id_o;
  logic              pkt_done_o;
  logic              trunc_o;

  uart_tx_arbiter #(.NumReq(NumReq), .MaxPktLen(MaxPktLen)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_last_i(req_last_i),
    .req_ready_o(req_ready_o), .fifo_wvalid_o(fifo_wvalid_o),
    .fifo_wdata_o(fifo_wdata_o), .fifo_wready_i(fifo_wready_i),
    .busy_o(busy_o), .gnt_id_o(gnt_id_o), .pkt_done_o(pkt_done_o), .trunc_o(trunc_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Source byte queues, {last, data}
  logic [8:0] srcq [NumReq][$];
  // Monitor results
  logic [7:0] cap_q[$];
  logic [7:0] gnt_q[$];
  int pd_cnt = 0;
  int tr_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_seq(input string tag, input logic [7:0] got[$], input logic [7:0] exp[$]);
    logic [31:0] g;
    check({tag, " len"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (i < got.size()) g = 32'(got[i]);
      else g = 32'hDEAD;
      check($sformatf("%s[%0d]", tag, i), g, 32'(exp[i]));
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_mon();
    cap_q.delete();
    gnt_q.delete();
    pd_cnt = 0;
    tr_cnt = 0;
  endtask

  task automatic push_pkt(input int r, input int n, input logic [7:0] base);
    for (int k = 0; k < n; k++)
      srcq[r].push_back({(k == n - 1), 8'(32'(base) + 32'(k))});
  endtask

  function automatic bit src_empty();
    bit e = 1'b1;
    for (int i = 0; i < int'(NumReq); i++) if (srcq[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic wait_idle(input int budget, input string tag);
    bit ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      step();
      if (src_empty() && !busy_o) ok = 1'b1;
    end
    step();
    step();
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_busy(input string tag);
    int c = 0;
    do begin
      @(negedge clk_i);
      c++;
    end while (!busy_o && c < 50);
    check(tag, 32'(busy_o), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"},   32'(busy_o),        32'd0);
    check({tag, " wvalid"}, 32'(fifo_wvalid_o), 32'd0);
    check({tag, " wdata"},  32'(fifo_wdata_o),  32'd0);
    check({tag, " ready"},  32'(req_ready_o),   32'd0);
    check({tag, " gnt_id"}, 32'(gnt_id_o),      32'd0);
    check({tag, " done"},   32'(pkt_done_o),    32'd0);
    check({tag, " trunc"},  32'(trunc_o),       32'd0);
  endtask

  // Requester model: present queue heads, pop on observed handshakes.
  initial begin
    logic [NumReq-1:0] hs;
    req_valid_i = '0;
    req_data_i  = '0;
    req_last_i  = '0;
    forever begin
      @(negedge clk_i);
      hs = req_ready_o & req_valid_i;
      @(posedge clk_i);
      #1;
      for (int i = 0; i < int'(NumReq); i++)
        if (hs[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
      for (int i = 0; i < int'(NumReq); i++) begin
        if (srcq[i].size() > 0) begin
          req_valid_i[i]        = 1'b1;
          req_data_i[8*i +: 8]  = srcq[i][0][7:0];
          req_last_i[i]         = srcq[i][0][8];
        end else begin
          req_valid_i[i]        = 1'b0;
          req_data_i[8*i +: 8]  = 8'h00;
          req_last_i[i]         = 1'b0;
        end
      end
    end
  end

  // FIFO-side monitor: accepted bytes, grant order, status pulses.
  initial begin
    bit busy_prev = 1'b0;
    forever begin
      @(negedge clk_i);
      if (fifo_wvalid_o && fifo_wready_i) cap_q.push_back(fifo_wdata_o);
      if (busy_o && !busy_prev) gnt_q.push_back(8'(gnt_id_o));
      busy_prev = busy_o;
      if (pkt_done_o) pd_cnt++;
      if (trunc_o) tr_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] eb[$];
    logic [7:0] eg[$];
    rst_ni        = 1'b0;
    enable_i      = 1'b0;
    fifo_wready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check_all_zero("reset");
    step();
    rst_ni   = 1'b1;
    enable_i = 1'b1;

    // Round-robin: all four requesters with two 2-byte packets each
    clear_mon();
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < 4; r++) push_pkt(r, 2, 8'(r * 16 + p * 2));
    wait_idle(300, "rr drain");
    eb.delete(); eg.delete();
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < 4; r++) begin
        eg.push_back(8'(r));
        eb.push_back(8'(r * 16 + p * 2));
        eb.push_back(8'(r * 16 + p * 2 + 1));
      end
    check_seq("rr grants", gnt_q, eg);
    check_seq("rr bytes", cap_q, eb);
    check("rr done cnt", 32'(pd_cnt), 32'd8);
    check("rr trunc cnt", 32'(tr_cnt), 32'd0);

    // Single packet from requester 1
    clear_mon();
    srcq[1].push_back({1'b0, 8'hA5});
    srcq[1].push_back({1'b0, 8'h5A});
    srcq[1].push_back({1'b1, 8'hFF});
    wait_idle(100, "single drain");
    check_seq("single bytes", cap_q, '{8'hA5, 8'h5A, 8'hFF});
    check_seq("single grants", gnt_q, '{8'h01});
    check("single gnt_id", 32'(gnt_id_o), 32'd1);
    check("single done cnt", 32'(pd_cnt), 32'd1);
    check("single trunc cnt", 32'(tr_cnt), 32'd0);

    // Truncation: 20-byte packet from requester 2, others pending
    clear_mon();
    push_pkt(2, 20, 8'h40);
    push_pkt(3, 1, 8'h03);
    push_pkt(0, 1, 8'h01);
    wait_idle(300, "trunc drain");
    eb.delete();
    for (int k = 0; k < 16; k++) eb.push_back(8'(8'h40 + k));
    eb.push_back(8'h03);
    eb.push_back(8'h01);
    for (int k = 16; k < 20; k++) eb.push_back(8'(8'h40 + k));
    check_seq("trunc grants", gnt_q, '{8'h02, 8'h03, 8'h00, 8'h02});
    check_seq("trunc bytes", cap_q, eb);
    check("trunc done cnt", 32'(pd_cnt), 32'd4);
    check("trunc trunc cnt", 32'(tr_cnt), 32'd1);

    // Exactly MaxPktLen bytes with last on the final one: no truncation
    clear_mon();
    push_pkt(1, 16, 8'h80);
    wait_idle(200, "limit drain");
    check_seq("limit grants", gnt_q, '{8'h01});
    check("limit len", 32'(cap_q.size()), 32'd16);
    check("limit done cnt", 32'(pd_cnt), 32'd1);
    check("limit trunc cnt", 32'(tr_cnt), 32'd0);

    // Backpressure: FIFO full for 5 cycles mid-packet
    clear_mon();
    push_pkt(3, 4, 8'hC0);
    wait_busy("bp busy");
    step();
    fifo_wready_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      check($sformatf("bp ready c%0d", c), 32'(req_ready_o), 32'd0);
      check($sformatf("bp wvalid c%0d", c), 32'(fifo_wvalid_o), 32'd1);
      check($sformatf("bp wdata c%0d", c), 32'(fifo_wdata_o), 32'hC1);
    end
    step();
    fifo_wready_i = 1'b1;
    wait_idle(100, "bp drain");
    check_seq("bp bytes", cap_q, '{8'hC0, 8'hC1, 8'hC2, 8'hC3});
    check("bp done cnt", 32'(pd_cnt), 32'd1);

    // Enable dropped mid-packet: packet finishes, no further grant
    clear_mon();
    push_pkt(0, 3, 8'hE0);
    push_pkt(1, 1, 8'hF1);
    wait_busy("en busy");
    step();
    enable_i = 1'b0;
    repeat (20) step();
    check_seq("en bytes", cap_q, '{8'hE0, 8'hE1, 8'hE2});
    check_seq("en grants", gnt_q, '{8'h00});
    check("en busy after", 32'(busy_o), 32'd0);
    check("en ready after", 32'(req_ready_o), 32'd0);
    check("en done cnt", 32'(pd_cnt), 32'd1);
    clear_mon();
    enable_i = 1'b1;
    wait_idle(100, "reen drain");
    check_seq("reen bytes", cap_q, '{8'hF1});
    check_seq("reen grants", gnt_q, '{8'h01});

    // Reset mid-packet, then lowest valid index wins first
    clear_mon();
    push_pkt(2, 6, 8'h60);
    wait_busy("rst busy");
    step();
    step();
    push_pkt(0, 1, 8'h0A);
    push_pkt(3, 1, 8'h3A);
    rst_ni = 1'b0;
    @(negedge clk_i);
    check_all_zero("midrst");
    step();
    clear_mon();
    rst_ni = 1'b1;
    wait_idle(200, "postrst drain");
    check_seq("postrst grants", gnt_q, '{8'h00, 8'h02, 8'h03});
    check_seq("postrst bytes", cap_q, '{8'h0A, 8'h62, 8'h63, 8'h64, 8'h65, 8'h3A});
    check("postrst done cnt", 32'(pd_cnt), 32'd3);
    check("postrst trunc cnt", 32'(tr_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
